// File: rtl/psum_out_reader.sv
// rtl/psum_out_reader.sv - buffers wide dual-core psum words and drains them one bw_psum slot per handshake.
// Optional sticky drop flag: define READER_OVF_DETECT_EN to add the overflow port.
module psum_out_reader #(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+3,
  parameter int DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [2*col*bw_psum-1:0]    in_data,
  output logic                        in_ready,
  output logic                        o_valid,
  output logic [bw_psum-1:0]          o_data,
  output logic [$clog2(2*col)-1:0]    o_idx,
  output logic                        o_last,
  input  logic                        o_ready
`ifdef READER_OVF_DETECT_EN
  ,output logic                       overflow
`endif
);

  localparam int SLOTS = 2*col;
  localparam int W     = SLOTS*bw_psum;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW+1;
  localparam int IW    = $clog2(SLOTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(SLOTS-1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {IDLE, STREAM} state_t;

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  state_t        state;
  logic          push, pop, beat;

  // in_ready looks only at the registered count, so a pop cannot free a slot for the same edge
  assign in_ready = (count != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign beat     = o_valid && o_ready;
  assign pop      = beat && (o_idx == LAST_IDX);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  assign head   = mem[rd_ptr];
  assign o_data = head[int'(o_idx)*bw_psum +: bw_psum];
  assign o_last = o_valid && (o_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_idx   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case (state)
        IDLE: begin
          if (push) begin
            state   <= STREAM;
            o_valid <= 1'b1;
          end
        end
        STREAM: begin
          if (beat) begin
            if (o_idx == LAST_IDX) begin
              o_idx <= '0;
              // stay streaming when another word is queued or arriving this edge
              if (count_next == '0) begin
                state   <= IDLE;
                o_valid <= 1'b0;
              end
            end else begin
              o_idx <= o_idx + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef READER_OVF_DETECT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     overflow <= 1'b0;
    else if (in_valid && !in_ready) overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_psum_out_reader.sv
// tb/tb_psum_out_reader.sv - scoreboard bench for psum_out_reader.
// Covers overflow port checks when READER_OVF_DETECT_EN is defined.
module tb_psum_out_reader;

  localparam int SLOTS = 16;
  localparam int BWP   = 19;
  localparam int W     = SLOTS*BWP;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic           o_valid;
  logic [BWP-1:0] o_data;
  logic [3:0]     o_idx;
  logic           o_last;
  logic           o_ready;
`ifdef READER_OVF_DETECT_EN
  logic           overflow;
`endif

  typedef struct packed {
    logic [BWP-1:0] data;
    logic [3:0]     idx;
    logic           last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int checks   = 0;
  int failures = 0;
  int beats    = 0;
  int bubbles  = 0;
  bit started  = 0;

  psum_out_reader #(.col(8), .bw(8), .bw_psum(19), .DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .o_idx    (o_idx),
    .o_last   (o_last),
    .o_ready  (o_ready)
`ifdef READER_OVF_DETECT_EN
    ,.overflow(overflow)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int k = 0; k < SLOTS; k++) w[k*BWP +: BWP] = BWP'($urandom);
    return w;
  endfunction

  task automatic sb_push(input logic [W-1:0] w);
    beat_t b;
    for (int k = 0; k < SLOTS; k++) begin
      b.data = w[k*BWP +: BWP];
      b.idx  = 4'(k);
      b.last = (k == SLOTS-1);
      exp_q.push_back(b);
    end
  endtask

  // one clock: inspect the upcoming edge at negedge, then return at posedge+1
  task automatic tick();
    @(negedge clk);
    if (o_valid) started = 1;
    else if (started && exp_q.size() != 0) bubbles++;
    if (reset && o_valid && o_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected data=%h idx=%0d last=%0b required no beat", o_data, o_idx, o_last);
      end else begin
        mon_e = exp_q.pop_front();
        if ({o_data, o_idx, o_last} !== {mon_e.data, mon_e.idx, mon_e.last}) begin
          failures++;
          $display("FAIL beat data=%h idx=%0d last=%0b required data=%h idx=%0d last=%0b",
                   o_data, o_idx, o_last, mon_e.data, mon_e.idx, mon_e.last);
        end
      end
      beats++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [W-1:0] w, input logic exp_ready);
    in_valid = 1'b1;
    in_data  = w;
    checks++;
    if (in_ready !== exp_ready) begin
      failures++;
      $display("FAIL in_ready_at_write got=%b required=%b", in_ready, exp_ready);
    end
    if (exp_ready) sb_push(w);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout remaining=%0d required=0", exp_q.size());
    end
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_drain o_valid=%b required=0", o_valid);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({o_valid, o_idx, o_last, in_ready} !== {1'b0, 4'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL %s o_valid=%b o_idx=%0d o_last=%b in_ready=%b required 0 0 0 1",
               tag, o_valid, o_idx, o_last, in_ready);
    end
`ifdef READER_OVF_DETECT_EN
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL %s_overflow got=%b required=0", tag, overflow);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; o_ready = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_vals("reset_async");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    check_reset_vals("reset_release");
  endtask

  task automatic test_single();
    logic [W-1:0] w;
    int b0;
    for (int k = 0; k < SLOTS; k++) w[k*BWP +: BWP] = BWP'(k+1);
    o_ready = 1'b1;
    b0 = beats;
    started = 0;
    write_word(w, 1'b1);
    checks++;
    if ({o_valid, o_idx} !== {1'b1, 4'd0}) begin
      failures++;
      $display("FAIL single_latency o_valid=%b o_idx=%0d required 1 0", o_valid, o_idx);
    end
    drain(40);
    checks++;
    if (beats - b0 != 16) begin
      failures++;
      $display("FAIL single_beats got=%0d required=16", beats - b0);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w;
    logic [BWP+4:0] snap;
    int b0, n;
    for (int k = 0; k < SLOTS; k++) w[k*BWP +: BWP] = BWP'(k+1);
    b0 = beats;
    o_ready = 1'b1;
    write_word(w, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      o_ready = n[0] ? 1'b1 : 1'b0;
      if (!o_ready && o_valid) begin
        snap = {o_data, o_idx, o_last};
        tick();
        checks++;
        if ({o_data, o_idx, o_last} !== snap) begin
          failures++;
          $display("FAIL hold got=%h required=%h", {o_data, o_idx, o_last}, snap);
        end
      end else begin
        tick();
      end
      n++;
    end
    o_ready = 1'b1;
    drain(4);
    checks++;
    if (beats - b0 != 16) begin
      failures++;
      $display("FAIL backpressure_beats got=%0d required=16", beats - b0);
    end
  endtask

  task automatic test_overflow();
    int b0;
    o_ready = 1'b0;
    b0 = beats;
    for (int i = 0; i < 5; i++) write_word(rand_word(), (i < 4));
    checks++;
    if ({in_ready, o_valid, o_idx} !== {1'b0, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL full_state in_ready=%b o_valid=%b o_idx=%0d required 0 1 0", in_ready, o_valid, o_idx);
    end
`ifdef READER_OVF_DETECT_EN
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set got=%b required=1", overflow);
    end
`endif
    o_ready = 1'b1;
    drain(100);
    checks++;
    if (beats - b0 != 64) begin
      failures++;
      $display("FAIL overflow_beats got=%0d required=64", beats - b0);
    end
`ifdef READER_OVF_DETECT_EN
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky got=%b required=1", overflow);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] cur;
    int i, cyc, b0;
    o_ready = 1'b1;
    b0 = beats;
    bubbles = 0;
    started = 0;
    i = 0;
    cyc = 0;
    cur = rand_word();
    while ((i < 10 || exp_q.size() != 0) && cyc < 1000) begin
      if (i < 10) begin
        in_valid = 1'b1;
        in_data  = cur;
        if (in_ready) begin
          sb_push(cur);
          i++;
          tick();
          cur = rand_word();
        end else begin
          tick();
        end
      end else begin
        in_valid = 1'b0;
        tick();
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (cyc >= 1000) begin
      failures++;
      $display("FAIL b2b_timeout words=%0d remaining=%0d required 10 0", i, exp_q.size());
    end
    checks++;
    if (bubbles != 0) begin
      failures++;
      $display("FAIL b2b_bubbles got=%0d required=0", bubbles);
    end
    checks++;
    if (beats - b0 != 160) begin
      failures++;
      $display("FAIL b2b_beats got=%0d required=160", beats - b0);
    end
    checks++;
    if ({in_ready, o_valid} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_empty in_ready=%b o_valid=%b required 1 0", in_ready, o_valid);
    end
  endtask

  task automatic test_reset_mid();
    int n, b0;
    o_ready = 1'b0;
    write_word(rand_word(), 1'b1);
    write_word(rand_word(), 1'b1);
    o_ready = 1'b1;
    b0 = beats;
    n = 0;
    while (beats - b0 < 4 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if ({o_valid, o_idx} !== {1'b1, 4'd4}) begin
      failures++;
      $display("FAIL mid_beat5 o_valid=%b o_idx=%0d required 1 4", o_valid, o_idx);
    end
    #2 reset = 1'b0;
    #1 check_reset_vals("reset_mid");
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    check_reset_vals("reset_mid_release");
    b0 = beats;
    write_word(rand_word(), 1'b1);
    checks++;
    if ({o_valid, o_idx} !== {1'b1, 4'd0}) begin
      failures++;
      $display("FAIL mid_new_start o_valid=%b o_idx=%0d required 1 0", o_valid, o_idx);
    end
    drain(40);
    repeat (3) tick();
    checks++;
    if (beats - b0 != 16) begin
      failures++;
      $display("FAIL mid_new_beats got=%0d required=16", beats - b0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
